// File: rtl/led_fade_pwm_pkg.sv
// Shared constants and types for the LED afterglow driver.
package led_pkg;

  // Default geometry and decay rate of the fade driver.
  localparam int LED_CHANNELS   = 8;
  localparam int LED_PWM_BITS   = 8;
  localparam int LED_DECAY_LOG2 = 16;
  localparam int LED_DECAY_STEP = 8;

  // Brightness value at default PWM resolution.
  typedef logic [LED_PWM_BITS-1:0] bright_t;

  // Full-scale brightness for a given PWM width.
  function automatic int bmax_of(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

endpackage

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: brightness register with set/clear/saturating decay,
// rendered as a PWM bit by comparing against the shared PWM counter.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = LED_PWM_BITS,
  parameter int DECAY_STEP = LED_DECAY_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pattern_bit,
  input  logic                fade_en,
  input  logic                decay_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                lit
);

  localparam logic [PWM_BITS-1:0] BMAX = PWM_BITS'(bmax_of(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] bright_reg;
  logic [PWM_BITS-1:0] bright_next;

  // Update priority: a lit pattern bit beats bypass, which beats decay.
  always_comb begin
    bright_next = bright_reg;
    if (pattern_bit) begin
      bright_next = BMAX;
    end else if (!fade_en) begin
      bright_next = '0;
    end else if (decay_tick) begin
      bright_next = (bright_reg < STEP) ? '0 : bright_reg - STEP;
    end
  end

  // Brightness state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_reg <= '0;
    end else begin
      bright_reg <= bright_next;
    end
  end

  // PWM output: on while brightness exceeds the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= (bright_reg > pwm_cnt);
    end
  end

  assign lit = |bright_reg;

endmodule

// File: rtl/led_fade_pwm.sv
// LED afterglow driver: shared prescaler and PWM counter feeding one fade
// channel per pattern bit.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int CHANNELS   = LED_CHANNELS,
  parameter int PWM_BITS   = LED_PWM_BITS,
  parameter int DECAY_LOG2 = LED_DECAY_LOG2,
  parameter int DECAY_STEP = LED_DECAY_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pattern_in,
  input  logic                fade_en,
  output logic [CHANNELS-1:0] led_out,
  output logic                pwm_frame,
  output logic                active
);

  logic [DECAY_LOG2-1:0] prescaler_reg;
  logic [PWM_BITS-1:0]   pwm_cnt_reg;
  logic [CHANNELS-1:0]   pattern_q;
  logic [CHANNELS-1:0]   lit;
  logic                  decay_tick;

  // One decay tick per prescaler wrap.
  assign decay_tick = &prescaler_reg;

  // Free-running prescaler and PWM counter; both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_reg <= '0;
      pwm_cnt_reg   <= '0;
    end else begin
      prescaler_reg <= prescaler_reg + 1'b1;
      pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
    end
  end

  // Register the raw pattern, flag the PWM period start, summarize activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      pwm_frame <= 1'b0;
      active    <= 1'b0;
    end else begin
      pattern_q <= pattern_in;
      pwm_frame <= &pwm_cnt_reg;
      active    <= |lit;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      led_fade_channel #(
        .PWM_BITS   (PWM_BITS),
        .DECAY_STEP (DECAY_STEP)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .pattern_bit (pattern_q[gi]),
        .fade_en     (fade_en),
        .decay_tick  (decay_tick),
        .pwm_cnt     (pwm_cnt_reg),
        .led         (led_out[gi]),
        .lit         (lit[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: a time-based reference model checked
// every cycle, a vector table, and hand-written corner-case sequences.
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pattern_in = 8'hFF;
  logic       fade_en = 1'b1;

  logic [7:0] led_out, led_out_s;
  logic       pwm_frame, pwm_frame_s;
  logic       active, active_s;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  led_fade_pwm #(.CHANNELS(8), .PWM_BITS(8), .DECAY_LOG2(3), .DECAY_STEP(8)) dut (
    .clk(clk), .rst(rst), .pattern_in(pattern_in), .fade_en(fade_en),
    .led_out(led_out), .pwm_frame(pwm_frame), .active(active)
  );

  led_fade_pwm #(.CHANNELS(8), .PWM_BITS(8), .DECAY_LOG2(3), .DECAY_STEP(100)) dut_sat (
    .clk(clk), .rst(rst), .pattern_in(pattern_in), .fade_en(fade_en),
    .led_out(led_out_s), .pwm_frame(pwm_frame_s), .active(active_s)
  );

  // Reference model: time since reset drives the tick and PWM phase.
  int         m_cyc;
  logic [7:0] m_pat;
  int         m_br [2][8];
  logic [7:0] m_led [2];
  logic       m_active [2];
  logic       m_frame;

  function automatic int step_of(input int s);
    return (s == 0) ? 8 : 100;
  endfunction

  function automatic int next_bright(input int b, input bit p, input bit en, input bit tk, input int step);
    if (p) return 255;
    if (!en) return 0;
    if (tk) return (b < step) ? 0 : b - step;
    return b;
  endfunction

  function automatic bit any_lit(input int s);
    for (int c = 0; c < 8; c++) if (m_br[s][c] != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc   <= 0;
      m_pat   <= '0;
      m_frame <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        m_led[s]    <= '0;
        m_active[s] <= 1'b0;
        for (int c = 0; c < 8; c++) m_br[s][c] <= 0;
      end
    end else begin
      m_cyc   <= m_cyc + 1;
      m_pat   <= pattern_in;
      m_frame <= ((m_cyc % 256) == 255);
      for (int s = 0; s < 2; s++) begin
        m_active[s] <= any_lit(s);
        for (int c = 0; c < 8; c++) begin
          m_br[s][c]  <= next_bright(m_br[s][c], m_pat[c], fade_en, (m_cyc % 8) == 7, step_of(s));
          m_led[s][c] <= (m_br[s][c] > (m_cyc % 256));
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_led_out", led_out, m_led[0]);
      check("model_active", active, m_active[0]);
      check("model_pwm_frame", pwm_frame, m_frame);
      check("model_led_out_sat", led_out_s, m_led[1]);
      check("model_active_sat", active_s, m_active[1]);
      check("model_pwm_frame_sat", pwm_frame_s, m_frame);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [7:0] pat;
    bit         fade;
    int         run;
    bit         exp_active;
    bit         exp_dark;
  } vec_t;

  vec_t vecs [8];
  int   duty [4];
  int   w;
  int   t_first;
  int   gap;
  bit   seen;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all pattern bits high: outputs stay dark.
    cycles(1);
    chk_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycles(1);
      check("rst_led_out", led_out, 0);
      check("rst_pwm_frame", pwm_frame, 0);
      check("rst_active", active, 0);
    end
    pattern_in = 8'h00;
    rst = 1'b0;

    // pwm_frame period after release.
    seen = 1'b0;
    gap = 0;
    t_first = 0;
    for (int i = 0; i < 600; i++) begin
      cycles(1);
      if (pwm_frame) begin
        if (!seen) begin
          seen = 1'b1;
          t_first = i;
        end else if (gap == 0) begin
          gap = i - t_first;
        end
      end
      if (led_out != 0) check("release_dark", led_out, 0);
    end
    check("frame_period", gap, 256);

    // Single-cycle pulse on channel 0 at a known PWM phase.
    for (int i = 0; i < 300 && (m_cyc % 256) != 10; i++) cycles(1);
    check("pulse_align", m_cyc % 256, 10);
    pattern_in = 8'h01;
    cycles(1);
    pattern_in = 8'h00;
    check("pulse_led_n", led_out[0], 0);
    check("pulse_active_n", active, 0);
    cycles(1);
    check("pulse_led_n1", led_out[0], 0);
    check("pulse_active_n1", active, 0);
    cycles(1);
    check("pulse_led_n2", led_out[0], 1);
    check("pulse_active_n2", active, 1);
    check("pulse_active_sat_n2", active_s, 1);
    // Saturating DUT: 255 -> 155 -> 55 -> 0 within 3 ticks; a wrap would stay lit.
    cycles(35);
    check("sat_no_wrap", active_s, 0);
    check("fade_still_on", active, 1);

    // Per-frame duty of the fading channel must not increase.
    for (int k = 0; k < 4; k++) duty[k] = 0;
    duty[0] = 1;
    w = 0;
    for (int i = 0; i < 900; i++) begin
      cycles(1);
      if (pwm_frame && w < 3) w++;
      duty[w] += int'(led_out[0]);
    end
    check("duty_first_nonzero", int'(duty[0] > 0), 1);
    for (int k = 0; k < 3; k++) check("duty_monotonic", int'(duty[k+1] <= duty[k]), 1);
    check("duty_final_zero", duty[3], 0);

    // Vector table: {pattern, fade_en, cycles, expected active, expect all dark}.
    vecs[0] = '{8'hFF, 1'b1, 5,    1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 3,    1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1,    1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 3,    1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 300,  1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1000, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 1'b0, 10,   1'b1, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 3,    1'b0, 1'b1};
    for (int v = 0; v < 8; v++) begin
      pattern_in = vecs[v].pat;
      fade_en    = vecs[v].fade;
      cycles(vecs[v].run);
      check($sformatf("vec%0d_active", v), active, vecs[v].exp_active);
      check($sformatf("vec%0d_active_sat", v), active_s, vecs[v].exp_active);
      if (vecs[v].exp_dark) check($sformatf("vec%0d_dark", v), led_out, 0);
    end

    // Asynchronous reset in the middle of a fade.
    fade_en = 1'b1;
    pattern_in = 8'hFF;
    cycles(2);
    pattern_in = 8'h00;
    cycles(40);
    check("midfade_lit", active, 1);
    rst = 1'b1;
    #1;
    check("async_rst_led", led_out, 0);
    check("async_rst_active", active, 0);
    check("async_rst_active_sat", active_s, 0);
    cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (led_out != 0 || active) begin
        check("post_rst_dark", {led_out, active}, 0);
      end
    end
    check("post_rst_active", active, 0);

    // Randomized sparse patterns with occasional bypass toggles.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 8; c++) pattern_in[c] = ($urandom_range(15) == 0);
      if ($urandom_range(199) == 0) fade_en = ~fade_en;
      cycles(1);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
